// File: rtl/instruction_types.sv
// instruction_types: opcode classes, sequencer states and datapath mux encodings shared by control and datapath.
package instruction_types;
  typedef enum logic [6:0] {
    R_TYPE    = 7'b0110011,
    I_TYPE    = 7'b0010011,
    LOAD_TYPE = 7'b0000011,
    S_TYPE    = 7'b0100011,
    B_TYPE    = 7'b1100011,
    JAL       = 7'b1101111,
    JALR      = 7'b1100111,
    LUI       = 7'b0110111,
    AUIPC     = 7'b0010111
  } opcode_t;
  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WRITEBACK, FAULT} ctrl_state_t;
  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;
  localparam logic [1:0] WB_ALU   = 2'd0;
  localparam logic [1:0] WB_MEM   = 2'd1;
  localparam logic [1:0] WB_PC4   = 2'd2;
  function automatic logic is_legal(input logic [6:0] op);
    return op inside {R_TYPE, I_TYPE, LOAD_TYPE, S_TYPE, B_TYPE, JAL, JALR, LUI, AUIPC};
  endfunction
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: saturating wait counter; timeout fires on the waiting cycle whose count reaches MEM_TIMEOUT.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TIMER_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic timeout
);
  localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(MEM_TIMEOUT);
  logic [TIMER_W-1:0] count;
  always_ff @(posedge clk)
    if (rst || clear) count <= '0;
    else if (en && count != LIMIT) count <= count + 1'b1;
  assign timeout = en && (count >= LIMIT - 1'b1);
endmodule

// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: multi-cycle RV32I sequencer driving datapath selects, enables and the memory port.
module cpu_control_fsm
  import instruction_types::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TIMER_W = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op_code,
  input  logic       branch_cond,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       alu_in1_sel,
  output logic       alu_in2_sel,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic       fault,
  output logic       retired
);
  ctrl_state_t state, next;
  opcode_t cls;
  logic waiting, timeout;
  logic in_fetch, in_ex, in_mem, in_wb, br, st_done;
  assign waiting = (state == FETCH || state == MEM) && !mem_ready;
  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .TIMER_W(TIMER_W)) u_timer (
    .clk(clk),
    .rst(reset),
    .clear(next != state),
    .en(waiting),
    .timeout(timeout)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state <= FETCH;
      cls <= R_TYPE;
    end else begin
      state <= next;
      if (state == DECODE) cls <= opcode_t'(op_code);
    end
  always_comb begin
    next = state;
    case (state)
      FETCH:     next = mem_ready ? DECODE : timeout ? FAULT : FETCH;
      DECODE:    next = is_legal(op_code) ? EXECUTE : FAULT;
      EXECUTE:   next = (cls == LOAD_TYPE || cls == S_TYPE) ? MEM : cls == B_TYPE ? FETCH : WRITEBACK;
      MEM:       next = mem_ready ? (cls == S_TYPE ? FETCH : WRITEBACK) : timeout ? FAULT : MEM;
      WRITEBACK: next = FETCH;
      default:   next = FAULT;
    endcase
  end
  // Strobes are masked while reset is held so an in-flight access never commits.
  assign in_fetch     = !reset && state == FETCH;
  assign in_ex        = !reset && state == EXECUTE;
  assign in_mem       = !reset && state == MEM;
  assign in_wb        = !reset && state == WRITEBACK;
  assign br           = in_ex && cls == B_TYPE;
  assign st_done      = in_mem && cls == S_TYPE && mem_ready;
  assign mem_req      = in_fetch || in_mem;
  assign mem_addr_sel = in_mem;
  assign mem_we       = in_mem && cls == S_TYPE;
  assign ir_we        = in_fetch && mem_ready;
  assign alu_in1_sel  = (in_ex || in_mem || in_wb) && (cls == JAL || cls == AUIPC);
  assign alu_in2_sel  = (in_ex || in_mem || in_wb) && !(cls == R_TYPE || cls == B_TYPE);
  assign retired      = br || st_done || in_wb;
  assign pc_we        = retired;
  assign rf_we        = in_wb;
  assign pc_src       = in_wb ? (cls == JAL ? PC_IMM : cls == JALR ? PC_ALU : PC_PLUS4)
                      : (br && branch_cond) ? PC_IMM : PC_PLUS4;
  assign wb_sel       = !in_wb ? WB_ALU : cls == LOAD_TYPE ? WB_MEM
                      : (cls == JAL || cls == JALR) ? WB_PC4 : WB_ALU;
  assign fault        = state == FAULT;
endmodule

// File: tb/tb_cpu_control_fsm.sv
// tb_cpu_control_fsm: table-driven instruction runs plus hand-written fault, timeout and reset sequences.
module tb_cpu_control_fsm;
  logic clk = 0;
  logic reset = 1;
  logic [6:0] op_code = 7'b0110011;
  logic branch_cond = 0;
  logic mem_ready = 0;
  logic mem_req, mem_we, mem_addr_sel, ir_we, pc_we, alu_in1_sel, alu_in2_sel, rf_we, fault, retired;
  logic [1:0] pc_src, wb_sel;
  int tests = 0;
  int fails = 0;

  cpu_control_fsm #(.MEM_TIMEOUT(4), .TIMER_W(8)) dut (
    .clk(clk), .reset(reset), .op_code(op_code), .branch_cond(branch_cond), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .alu_in1_sel(alu_in1_sel), .alu_in2_sel(alu_in2_sel), .rf_we(rf_we),
    .wb_sel(wb_sel), .fault(fault), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    logic [6:0] op;
    bit bc;
    int fw;
    int mw;
    int cyc;
    int src;
    int wb;
    int rf;
    int mwe;
    int a1;
    int a2;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1;
    mem_ready = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset fault", fault, 0);
    chk("reset enables", {pc_we, rf_we, retired, ir_we}, 0);
    reset = 0;
    #1;
    chk("post-reset fetch", {mem_req, mem_addr_sel, mem_we, fault}, 4'b1000);
  endtask

  task automatic run(input vec_t v);
    int cyc = 0, fw = 0, mw = 0, pcn = 0, rfn = 0, irn = 0, mwn = 0, bad = 0;
    int src = -1, wbs = -1, a1 = -1, a2 = -1;
    bit done = 0;
    op_code = v.op;
    branch_cond = v.bc;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) @(negedge clk);
      mem_ready = (mem_req && !mem_addr_sel) ? (fw == v.fw) : (mem_req && mem_addr_sel) ? (mw == v.mw) : 1'b0;
      if (mem_req && !mem_addr_sel) fw++;
      if (mem_req && mem_addr_sel) mw++;
      #1;
      cyc++;
      if (ir_we) irn++;
      if (ir_we && !(mem_req && !mem_addr_sel)) bad++;
      if (mem_we) mwn++;
      if (mem_we && !mem_req) bad++;
      if (rf_we) begin rfn++; wbs = wb_sel; end
      if (pc_we) begin pcn++; src = pc_src; end
      if (retired) begin done = 1; a1 = alu_in1_sel; a2 = alu_in2_sel; end
    end
    @(negedge clk);
    chk({v.name, " cycles"}, cyc, v.cyc);
    chk({v.name, " pc_we count"}, pcn, 1);
    chk({v.name, " rf_we count"}, rfn, v.rf);
    chk({v.name, " ir_we count"}, irn, 1);
    chk({v.name, " mem_we cycles"}, mwn, v.mwe);
    chk({v.name, " strobe violations"}, bad, 0);
    chk({v.name, " pc_src"}, src, v.src);
    if (v.rf != 0) chk({v.name, " wb_sel"}, wbs, v.wb);
    chk({v.name, " alu_in1_sel"}, a1, v.a1);
    chk({v.name, " alu_in2_sel"}, a2, v.a2);
    chk({v.name, " fault"}, fault, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int mwn;
    tbl.push_back('{"R",      7'b0110011, 0, 0, 0, 4, 0, 0, 1, 0, 0, 0});
    tbl.push_back('{"LOAD_w3",7'b0000011, 0, 0, 3, 8, 0, 1, 1, 0, 0, 1});
    tbl.push_back('{"B_taken",7'b1100011, 1, 0, 0, 3, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{"B_not",  7'b1100011, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{"JALR",   7'b1100111, 0, 0, 0, 4, 2, 2, 1, 0, 0, 1});
    tbl.push_back('{"JAL",    7'b1101111, 0, 0, 0, 4, 1, 2, 1, 0, 1, 1});
    tbl.push_back('{"I_fw2",  7'b0010011, 0, 2, 0, 6, 0, 0, 1, 0, 0, 1});
    tbl.push_back('{"S_mw1",  7'b0100011, 0, 0, 1, 5, 0, 0, 0, 2, 0, 1});
    tbl.push_back('{"LUI",    7'b0110111, 0, 0, 0, 4, 0, 0, 1, 0, 0, 1});
    tbl.push_back('{"AUIPC",  7'b0010111, 0, 0, 0, 4, 0, 0, 1, 0, 1, 1});
    tbl.push_back('{"LOAD_fw1",7'b0000011,0, 1, 0, 6, 0, 1, 1, 0, 0, 1});
    tbl.push_back('{"R_fw3",  7'b0110011, 0, 3, 0, 7, 0, 0, 1, 0, 0, 0});
    tbl.push_back('{"S",      7'b0100011, 0, 0, 0, 4, 0, 0, 0, 1, 0, 1});

    do_reset();
    foreach (tbl[i]) run(tbl[i]);

    // illegal opcode: FETCH, DECODE, then terminal FAULT
    do_reset();
    op_code = 7'b1111111;
    mem_ready = 1;
    @(negedge clk); mem_ready = 0;
    @(negedge clk); #1;
    chk("illegal fault", fault, 1);
    mem_ready = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      chk("fault hold", {fault, mem_req, mem_we, ir_we, pc_we, rf_we, retired}, 7'b1000000);
    end
    do_reset();

    // fetch timeout: 4 waiting cycles, FAULT on the 5th
    mem_ready = 0;
    op_code = 7'b0110011;
    repeat (3) @(negedge clk);
    #1;
    chk("fetch wait 4 no fault", fault, 0);
    @(negedge clk); #1;
    chk("fetch timeout fault", fault, 1);

    // store with memory never ready in MEM
    do_reset();
    op_code = 7'b0100011;
    mem_ready = 1;
    @(negedge clk); mem_ready = 0;
    repeat (5) @(negedge clk);
    #1;
    chk("mem wait 4 no fault", fault, 0);
    chk("mem wait 4 mem_we", mem_we, 1);
    @(negedge clk); #1;
    chk("mem timeout fault", fault, 1);
    chk("mem timeout mem_we", mem_we, 0);

    // reset during the MEM phase of a store
    do_reset();
    op_code = 7'b0100011;
    mem_ready = 1;
    @(negedge clk); mem_ready = 0;
    @(negedge clk);
    @(negedge clk); #1;
    mwn = mem_we;
    chk("store first mem_we", mwn, 1);
    @(negedge clk);
    reset = 1;
    #1;
    chk("reset mid-mem pc_we", pc_we, 0);
    chk("reset mid-mem mem_we", mem_we, 0);
    @(negedge clk);
    reset = 0;
    #1;
    chk("after abort fetch", {mem_req, mem_addr_sel, mem_we, pc_we, fault}, 5'b10000);
    run(tbl[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
